// File: rtl/mac_err_pkg.sv
// Shared types and constants for the MAC error monitor: FSM states,
// accumulator/counter widths and the saturating-increment helper.
package mac_err_pkg;

    localparam int ACC_W = 40;
    localparam int CNT_W = 16;
    localparam int THR_W = 32;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC     = 2'd1,
        ST_ALARM   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic            en);
        return (en && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
    endfunction

endpackage

// File: rtl/mac_abs_diff.sv
// Clamped |golden - test| over sign-extended 40-bit operands, plus the
// strict "greater than threshold" mismatch flag.
module mac_abs_diff
    import mac_err_pkg::*;
(
    input  logic [ACC_W-1:0] golden,
    input  logic [ACC_W-1:0] test,
    input  logic [THR_W-1:0] threshold,
    output logic [ACC_W-1:0] abs_diff,
    output logic             mismatch
);

    logic signed [ACC_W:0] diff;
    logic        [ACC_W:0] mag;

    always_comb begin
        diff     = $signed({golden[ACC_W-1], golden}) - $signed({test[ACC_W-1], test});
        mag      = diff[ACC_W] ? $unsigned(-diff) : $unsigned(diff);
        // Magnitude of a 41-bit negative can need bit 40; saturate instead of wrapping.
        abs_diff = mag[ACC_W] ? {ACC_W{1'b1}} : mag[ACC_W-1:0];
        mismatch = abs_diff > {{(ACC_W-THR_W){1'b0}}, threshold};
    end

endmodule

// File: rtl/mac_err_monitor.sv
// Compares the TCB and TCB-shift MAC accumulators against the exact MAC,
// keeping mismatch statistics and an alarm FSM driven by the shift path.
module mac_err_monitor
    import mac_err_pkg::*;
#(
    parameter int MAC_LAT   = 4,
    parameter int ALARM_LIM = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             ce,
    input  logic             sload,
    input  logic [ACC_W-1:0] mac_out,
    input  logic [ACC_W-1:0] mac_tcb_out,
    input  logic [ACC_W-1:0] mac_tcb_shift_out,
    input  logic [THR_W-1:0] constant_threshold,
    input  logic             clr,
    output logic             sample_valid,
    output logic [CNT_W-1:0] err_tcb_cnt,
    output logic [CNT_W-1:0] err_shift_cnt,
    output logic [ACC_W-1:0] max_err_shift,
    output logic [CNT_W-1:0] win_cnt,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(ALARM_LIM);

    logic [MAC_LAT-1:0] v_line;
    logic [MAC_LAT-1:0] s_line;
    logic               v_d;
    logic               s_d;
    logic               sample;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tcb_q, tcb_d;
    logic [CNT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [ACC_W-1:0]   max_q, max_d;

    logic [ACC_W-1:0]   abs_tcb;
    logic [ACC_W-1:0]   abs_shift;
    logic               mis_tcb;
    logic               mis_shift;
    logic               unused_abs_tcb;

    assign v_d    = v_line[MAC_LAT-1];
    assign s_d    = s_line[MAC_LAT-1];
    assign sample = clk_en & v_d;

    mac_abs_diff u_diff_tcb (
        .golden    (mac_out),
        .test      (mac_tcb_out),
        .threshold (constant_threshold),
        .abs_diff  (abs_tcb),
        .mismatch  (mis_tcb)
    );

    mac_abs_diff u_diff_shift (
        .golden    (mac_out),
        .test      (mac_tcb_shift_out),
        .threshold (constant_threshold),
        .abs_diff  (abs_shift),
        .mismatch  (mis_shift)
    );

    // Only the TCB mismatch flag is tracked; its magnitude is not reported.
    assign unused_abs_tcb = ^abs_tcb;

    // Control pipe aligning ce/sload with the MAC accumulator outputs.
    // NOTE: sequential state uses non-blocking (<=) so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the pipe.
    // NOTE: the delay line is a shift register of flops, not a RAM, so it is
    // reset to discard samples that were in flight when reset arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_line <= '0;
            s_line <= '0;
        end else if (clk_en) begin
            v_line[0] <= ce;
            s_line[0] <= sload;
            for (int i = 1; i < MAC_LAT; i++) begin
                v_line[i] <= v_line[i-1];
                s_line[i] <= s_line[i-1];
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        tcb_d   = tcb_q;
        shift_d = shift_q;
        win_d   = win_q;
        max_d   = max_q;

        if (sample) begin
            tcb_d   = sat_inc(tcb_q, mis_tcb);
            shift_d = sat_inc(shift_q, mis_shift);
            win_d   = sat_inc(win_q, s_d && (state_q != ST_IDLE));
            if (abs_shift > max_q) begin
                max_d = abs_shift;
            end
        end

        case (state_q)
            ST_IDLE:  if (sample && s_d)               state_d = ST_ACC;
            ST_ACC:   if (sample && (shift_d >= LIM))  state_d = ST_ALARM;
            ST_ALARM: state_d = ST_ALARM;
            default:  state_d = ST_IDLE;
        endcase

        // Clear overrides any coincident sample; the delay line is untouched.
        if (clr) begin
            state_d = ST_IDLE;
            tcb_d   = '0;
            shift_d = '0;
            win_d   = '0;
            max_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tcb_q   <= '0;
            shift_q <= '0;
            win_q   <= '0;
            max_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            tcb_q   <= tcb_d;
            shift_q <= shift_d;
            win_q   <= win_d;
            max_q   <= max_d;
        end
    end

    // Pulse register is deliberately not gated so it drops to 0 while clk_en=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= sample;
        end
    end

    assign err_tcb_cnt   = tcb_q;
    assign err_shift_cnt = shift_q;
    assign max_err_shift = max_q;
    assign win_cnt       = win_q;
    assign alarm         = (state_q == ST_ALARM);
    assign state         = state_q;

endmodule

// File: tb/tb_mac_err_monitor.sv
// Directed bench for mac_err_monitor: latency, thresholds, clamping,
// saturation, alarm FSM, clear collision, clock-enable gap and async reset.
module tb_mac_err_monitor;

    localparam int MAC_LAT   = 4;
    localparam int ALARM_LIM = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        ce;
    logic        sload;
    logic [39:0] mac_out;
    logic [39:0] mac_tcb_out;
    logic [39:0] mac_tcb_shift_out;
    logic [31:0] constant_threshold;
    logic        clr;
    logic        sample_valid;
    logic [15:0] err_tcb_cnt;
    logic [15:0] err_shift_cnt;
    logic [39:0] max_err_shift;
    logic [15:0] win_cnt;
    logic        alarm;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    mac_err_monitor #(.MAC_LAT(MAC_LAT), .ALARM_LIM(ALARM_LIM)) dut (
        .clk                (clk),
        .rst                (rst),
        .clk_en             (clk_en),
        .ce                 (ce),
        .sload              (sload),
        .mac_out            (mac_out),
        .mac_tcb_out        (mac_tcb_out),
        .mac_tcb_shift_out  (mac_tcb_shift_out),
        .constant_threshold (constant_threshold),
        .clr                (clr),
        .sample_valid       (sample_valid),
        .err_tcb_cnt        (err_tcb_cnt),
        .err_shift_cnt      (err_shift_cnt),
        .max_err_shift      (max_err_shift),
        .win_cnt            (win_cnt),
        .alarm              (alarm),
        .state              (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One ce pulse, then wait until its sample has been taken and the pulse has ended.
    task automatic pulse_sample(input logic with_sload);
        ce = 1'b1; sload = with_sload;
        step();
        ce = 1'b0; sload = 1'b0;
        repeat (MAC_LAT + 1) step();
    endtask

    task automatic check_zeroed(input string tag);
        checks++; if (err_tcb_cnt !== 16'd0) begin errors++; $display("FAIL %s_err_tcb: got %0h expected 0", tag, err_tcb_cnt); end
        checks++; if (err_shift_cnt !== 16'd0) begin errors++; $display("FAIL %s_err_shift: got %0h expected 0", tag, err_shift_cnt); end
        checks++; if (max_err_shift !== 40'd0) begin errors++; $display("FAIL %s_max: got %0h expected 0", tag, max_err_shift); end
        checks++; if (win_cnt !== 16'd0) begin errors++; $display("FAIL %s_win: got %0h expected 0", tag, win_cnt); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL %s_state: got %0d expected 0", tag, state); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL %s_alarm: got %0b expected 0", tag, alarm); end
    endtask

    task automatic test_reset();
        repeat (2) step();
        check_zeroed("reset");
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %0b expected 0", sample_valid); end
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int first  = -1;
        int pulses = 0;
        mac_out = 40'd5; mac_tcb_out = 40'd5; mac_tcb_shift_out = 40'd5; constant_threshold = 32'd0;
        for (int i = 0; i < 20; i++) begin
            ce = (i < 10); sload = (i == 0);
            step();
            if (sample_valid === 1'b1) begin
                if (first < 0) first = i + 1;
                pulses++;
            end
        end
        ce = 1'b0; sload = 1'b0;
        checks++; if (first !== MAC_LAT + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", first, MAC_LAT + 1); end
        checks++; if (pulses !== 10) begin errors++; $display("FAIL basic_pulses: got %0d expected 10", pulses); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_state: got %0d expected 1", state); end
        checks++; if (err_tcb_cnt !== 16'd0 || err_shift_cnt !== 16'd0) begin errors++; $display("FAIL basic_errs: got %0h/%0h expected 0/0", err_tcb_cnt, err_shift_cnt); end
        checks++; if (win_cnt !== 16'd0) begin errors++; $display("FAIL basic_win: got %0d expected 0", win_cnt); end
    endtask

    task automatic test_windows();
        repeat (3) pulse_sample(1'b1);
        checks++; if (win_cnt !== 16'd3) begin errors++; $display("FAIL win_three: got %0d expected 3", win_cnt); end
        pulse_sample(1'b0);
        checks++; if (win_cnt !== 16'd3) begin errors++; $display("FAIL win_no_sload: got %0d expected 3", win_cnt); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL win_state: got %0d expected 1", state); end
    endtask

    task automatic test_threshold();
        mac_out = 40'd1000; mac_tcb_out = 40'd1000; constant_threshold = 32'd10;
        mac_tcb_shift_out = 40'd990;
        pulse_sample(1'b0);
        checks++; if (err_shift_cnt !== 16'd0) begin errors++; $display("FAIL thr_990_cnt: got %0d expected 0", err_shift_cnt); end
        checks++; if (max_err_shift !== 40'd10) begin errors++; $display("FAIL thr_990_max: got %0d expected 10", max_err_shift); end
        mac_tcb_shift_out = 40'd1010;
        pulse_sample(1'b0);
        checks++; if (err_shift_cnt !== 16'd0) begin errors++; $display("FAIL thr_1010_cnt: got %0d expected 0", err_shift_cnt); end
        mac_tcb_shift_out = 40'd989;
        pulse_sample(1'b0);
        checks++; if (err_shift_cnt !== 16'd1) begin errors++; $display("FAIL thr_989_cnt: got %0d expected 1", err_shift_cnt); end
        checks++; if (max_err_shift !== 40'd11) begin errors++; $display("FAIL thr_989_max: got %0d expected 11", max_err_shift); end
        checks++; if (err_tcb_cnt !== 16'd0) begin errors++; $display("FAIL thr_tcb: got %0d expected 0", err_tcb_cnt); end
    endtask

    task automatic test_clamp();
        mac_out = 40'h80_0000_0000; mac_tcb_out = 40'h7F_FFFF_FFFF; mac_tcb_shift_out = 40'h7F_FFFF_FFFF;
        constant_threshold = 32'hFFFF_FFFF;
        pulse_sample(1'b0);
        checks++; if (err_tcb_cnt !== 16'd1) begin errors++; $display("FAIL clamp_tcb: got %0d expected 1", err_tcb_cnt); end
        checks++; if (err_shift_cnt !== 16'd2) begin errors++; $display("FAIL clamp_shift: got %0d expected 2", err_shift_cnt); end
        checks++; if (max_err_shift !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL clamp_max: got %0h expected ffffffffff", max_err_shift); end
    endtask

    task automatic test_alarm();
        int bad = 0;
        clr = 1'b1; step(); clr = 1'b0;
        check_zeroed("clr1");
        mac_out = 40'd100; mac_tcb_out = 40'd100; mac_tcb_shift_out = 40'd100; constant_threshold = 32'd0;
        pulse_sample(1'b1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL alarm_enter_acc: got %0d expected 1", state); end
        mac_tcb_shift_out = 40'd0;
        for (int i = 0; i < 14; i++) begin
            ce = (i < 8);
            step();
            if (alarm !== (err_shift_cnt >= 16'(ALARM_LIM))) bad++;
        end
        ce = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL alarm_timing: got %0d bad cycles expected 0", bad); end
        checks++; if (err_shift_cnt !== 16'd8) begin errors++; $display("FAIL alarm_cnt: got %0d expected 8", err_shift_cnt); end
        checks++; if (state !== 2'd2 || alarm !== 1'b1) begin errors++; $display("FAIL alarm_state: got %0d/%0b expected 2/1", state, alarm); end
        ce = 1'b1;
        repeat (70000) step();
        ce = 1'b0;
        repeat (MAC_LAT + 2) step();
        checks++; if (err_shift_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_shift: got %0h expected ffff", err_shift_cnt); end
        checks++; if (err_tcb_cnt !== 16'd0) begin errors++; $display("FAIL sat_tcb: got %0h expected 0", err_tcb_cnt); end
        checks++; if (max_err_shift !== 40'd100) begin errors++; $display("FAIL sat_max: got %0d expected 100", max_err_shift); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL sat_state: got %0d expected 2", state); end
        clr = 1'b1; step(); clr = 1'b0;
        check_zeroed("clr2");
    endtask

    task automatic test_clr_collision();
        mac_out = 40'd100; mac_tcb_out = 40'd100; mac_tcb_shift_out = 40'd0; constant_threshold = 32'd0;
        ce = 1'b1; step(); ce = 1'b0;
        repeat (MAC_LAT - 1) step();
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL coll_sv: got %0b expected 1", sample_valid); end
        checks++; if (err_shift_cnt !== 16'd0) begin errors++; $display("FAIL coll_cnt: got %0d expected 0", err_shift_cnt); end
        checks++; if (max_err_shift !== 40'd0) begin errors++; $display("FAIL coll_max: got %0d expected 0", max_err_shift); end
        step();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL coll_sv_end: got %0b expected 0", sample_valid); end
    endtask

    task automatic test_gap();
        int          pulses = 0;
        int          gap_sv = 0;
        logic [15:0] frozen = '0;
        for (int i = 0; i < 20; i++) begin
            ce = (i < 6);
            clk_en = !(i >= 7 && i <= 9);
            step();
            if (sample_valid === 1'b1) pulses++;
            if (i >= 7 && i <= 9 && sample_valid !== 1'b0) gap_sv++;
            if (i == 6) frozen = err_shift_cnt;
            if (i == 9) begin
                checks++; if (err_shift_cnt !== frozen) begin errors++; $display("FAIL gap_frozen: got %0d expected %0d", err_shift_cnt, frozen); end
            end
        end
        ce = 1'b0; clk_en = 1'b1;
        checks++; if (frozen !== 16'd3) begin errors++; $display("FAIL gap_before: got %0d expected 3", frozen); end
        checks++; if (gap_sv !== 0) begin errors++; $display("FAIL gap_sv: got %0d pulses expected 0", gap_sv); end
        checks++; if (pulses !== 6) begin errors++; $display("FAIL gap_pulses: got %0d expected 6", pulses); end
        checks++; if (err_shift_cnt !== 16'd6) begin errors++; $display("FAIL gap_cnt: got %0d expected 6", err_shift_cnt); end
        checks++; if (win_cnt !== 16'd0 || state !== 2'd0) begin errors++; $display("FAIL gap_fsm: got %0d/%0d expected 0/0", win_cnt, state); end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        ce = 1'b1;
        repeat (3) step();
        ce = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_zeroed("arst");
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL arst_sv: got %0b expected 0", sample_valid); end
        #3 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (sample_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL arst_ghost: got %0d pulses expected 0", pulses); end
        ce = 1'b1; step(); ce = 1'b0;
        if (sample_valid === 1'b1) pulses++;
        for (int i = 0; i < 8; i++) begin
            step();
            if (sample_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL arst_new: got %0d pulses expected 1", pulses); end
        checks++; if (err_shift_cnt !== 16'd1) begin errors++; $display("FAIL arst_cnt: got %0d expected 1", err_shift_cnt); end
    endtask

    initial begin
        rst = 1'b0; clk_en = 1'b1; ce = 1'b0; sload = 1'b0; clr = 1'b0;
        mac_out = '0; mac_tcb_out = '0; mac_tcb_shift_out = '0; constant_threshold = '0;
        test_reset();
        test_basic();
        test_windows();
        test_threshold();
        test_clamp();
        test_alarm();
        test_clr_collision();
        test_gap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_err_monitor.md
MAC_ERR_MONITOR -- requirements
Module: mac_err_monitor

Interface
REQ-001 Parameter MAC_LAT, default 4: cycles from ce/sload/operands sampled to the corresponding accumulator value on the MAC outputs.
REQ-002 Parameter ALARM_LIM, default 8: shift-path mismatch count at which the alarm state is entered.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 clk_en  input  1  global enable; while 0, all state holds.
REQ-006 ce  input  1  MAC operand-valid strobe, the same signal that drives the three MACs.
REQ-007 sload  input  1  MAC accumulator-reload strobe, the same signal that drives the three MACs.
REQ-008 mac_out  input  40  exact MAC accumulator (golden).
REQ-009 mac_tcb_out  input  40  TCB MAC accumulator.
REQ-010 mac_tcb_shift_out  input  40  TCB-shift MAC accumulator.
REQ-011 constant_threshold  input  32  unsigned error tolerance, zero-extended for compares.
REQ-012 clr  input  1  synchronous statistics clear; acts only when clk_en=1.
REQ-013 sample_valid  output  1  one-cycle pulse marking a compared sample.
REQ-014 err_tcb_cnt  output  16  saturating count of TCB mismatches.
REQ-015 err_shift_cnt  output  16  saturating count of shift-path mismatches.
REQ-016 max_err_shift  output  40  largest |mac_out - mac_tcb_shift_out| seen.
REQ-017 win_cnt  output  16  saturating count of completed accumulation windows.
REQ-018 alarm  output  1  high while the FSM is in ALARM.
REQ-019 state  output  2  current FSM state encoding.

Function
REQ-020 A MAC_LAT-deep delay line of {ce, sload} SHALL advance only when clk_en=1, producing v_d and s_d aligned with the MAC outputs.
REQ-021 Every cycle with clk_en=1 and v_d=1 SHALL be a sample; sample_valid SHALL pulse exactly 1 cycle later (total latency MAC_LAT+1 from ce).
REQ-022 The differences SHALL be 41-bit signed (40-bit operands sign-extended), golden minus test; the absolute value SHALL clamp to 2^40-1.
REQ-023 A mismatch SHALL be |diff| > threshold (strictly greater); equality is not a mismatch.
REQ-024 err_tcb_cnt and err_shift_cnt SHALL each increment by 1 per mismatching sample and saturate at 0xFFFF.
REQ-025 On a sample, max_err_shift SHALL load |diff_shift| when that value exceeds the current max_err_shift.
REQ-026 win_cnt SHALL increment on each sample with s_d=1 while state is not IDLE, and saturate at 0xFFFF.
REQ-027 FSM encodings: IDLE=0, ACC=1, ALARM=2; value 3 is illegal and SHALL recover to IDLE.
REQ-028 IDLE->ACC on the first sample with s_d=1; samples in IDLE before that SHALL still be compared and counted.
REQ-029 ACC->ALARM in the cycle err_shift_cnt's next value reaches ALARM_LIM; ALARM is left only by clr or reset.
REQ-030 clr SHALL zero all counters and max_err_shift, set state to IDLE, and leave the delay line intact.
REQ-031 If clr and a sample occur in the same cycle, clr SHALL win and the sample SHALL NOT be counted; sample_valid still pulses.
REQ-032 With clk_en=0, sample_valid SHALL be 0 and every register SHALL hold its value.

Reset
REQ-033 On rst=0 the delay line, all counters, max_err_shift and sample_valid SHALL be 0, and state SHALL be IDLE, regardless of clk.
REQ-034 Samples in flight at reset SHALL be discarded; the first sample after reset SHALL come from a ce sampled after reset release.

Structure
REQ-035 Package mac_err_pkg SHALL hold the FSM state type and encodings, ACC_W=40, CNT_W=16 and CNT_MAX.
REQ-036 One combinational sub-module, mac_abs_diff, SHALL compute the clamped absolute difference and the mismatch flag; it is instantiated twice.

Verification
REQ-037 Equal inputs, threshold 0, 10 ce cycles with sload on the first -> 10 sample_valid pulses starting cycle MAC_LAT+1, counters 0, state ACC.
REQ-038 mac_out=1000, shift path 990 and 1010, threshold 10 -> no mismatch; shift path 989 with the same threshold -> err_shift_cnt+1, max_err_shift=11.
REQ-039 mac_out=0x80_0000_0000, tcb=0x7F_FFFF_FFFF -> |diff| clamped to 2^40-1, err_tcb_cnt+1.
REQ-040 8 consecutive shift mismatches -> alarm rises on the 8th count; a further 70000 mismatches -> err_shift_cnt=0xFFFF; clr -> all 0, state IDLE.
REQ-041 clr coincident with a mismatch sample, and clk_en=0 for 3 cycles mid-stream -> nothing counted on the clr cycle; everything frozen during the clk_en gap, no pulses lost or duplicated afterwards.
REQ-042 rst=0 asserted between clk edges with 3 samples in flight -> outputs 0 immediately, no sample_valid pulses after release until a new ce.
